// File: rtl/mem_arb_pkg.sv
// Shared types and the cyclic priority search used by the memory port arbiter.
// Pure combinational helpers; no state lives here.
package mem_arb_pkg;

   localparam int NREQ_MAX = 4;

   typedef struct packed {
      logic       vld;
      logic [1:0] owner;
   } tag_t;

   // Returns {found, index} of the first set bit of req at or after ptr, wrapping at n.
   function automatic logic [2:0] rr_pick(input logic [NREQ_MAX-1:0] req,
                                          input logic [1:0]          ptr,
                                          input int                  n);
      logic [2:0] res;
      int         idx;
      res = '0;
      for (int i = NREQ_MAX - 1; i >= 0; i--) begin
         if (i < n) begin
            idx = int'(ptr) + i;
            if (idx >= n) idx = idx - n;
            if (req[2'(idx)]) res = {1'b1, 2'(idx)};
         end
      end
      return res;
   endfunction

endpackage

// File: rtl/mem_port_arbiter_rr_picker.sv
// Combinational round-robin select: zero latency, no backpressure of its own.
// winner is only meaningful while any is high.
module rr_picker
   import mem_arb_pkg::*;
#(
   parameter int NREQ = 2,
   parameter int PW   = $clog2(NREQ)
) (
   input  logic [NREQ-1:0] req,
   input  logic [PW-1:0]   ptr,
   output logic            any,
   output logic [1:0]      winner
);

   logic [2:0] pick;

   always_comb begin
      pick   = rr_pick(NREQ_MAX'(req), 2'(ptr), NREQ);
      any    = pick[2];
      winner = pick[1:0];
   end

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin share of one single-ported memory slave; grant is same-cycle, read data returns
// RD_LAT cycles after grant. A slave stall holds the current winner in place (no re-arbitration).
module mem_port_arbiter
   import mem_arb_pkg::*;
#(
   parameter int NREQ   = 2,
   parameter int AW     = 32,
   parameter int DW     = 32,
   parameter int RD_LAT = 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [NREQ-1:0]   req_rd,
   input  logic [NREQ-1:0]   req_wr,
   input  logic [NREQ*AW-1:0] req_addr,
   input  logic [NREQ*DW-1:0] req_wdata,
   output logic [NREQ-1:0]   req_rd_gnt,
   output logic [NREQ-1:0]   req_wr_gnt,
   output logic [DW-1:0]     req_rdata,
   output logic [NREQ-1:0]   req_rvalid,
   output logic              mem_rd_req,
   output logic              mem_wr_req,
   output logic [AW-1:0]     mem_addr,
   output logic [DW-1:0]     mem_wdata,
   input  logic              mem_rd_gnt,
   input  logic              mem_wr_gnt,
   input  logic [DW-1:0]     mem_rd_data
);

   localparam int PW = $clog2(NREQ);

   logic [PW-1:0]   rr_ptr;
   logic [NREQ-1:0] req_any;
   logic            any;
   logic [1:0]      win;
   logic [AW-1:0]   sel_addr;
   logic [DW-1:0]   sel_wdata;
   logic            win_rd;
   logic            win_wr;
   logic            rd_fire;
   logic            wr_fire;
   tag_t            tag_q [RD_LAT];

   assign req_any = req_rd | req_wr;

   rr_picker #(.NREQ(NREQ), .PW(PW)) u_pick (
      .req    (req_any),
      .ptr    (rr_ptr),
      .any    (any),
      .winner (win)
   );

   // Write wins over a simultaneous read from the same requester; the read stays pending.
   always_comb begin
      sel_addr  = '0;
      sel_wdata = '0;
      win_rd    = 1'b0;
      win_wr    = 1'b0;
      for (int i = 0; i < NREQ; i++) begin
         if (win == 2'(i)) begin
            sel_addr  = req_addr[i*AW +: AW];
            sel_wdata = req_wdata[i*DW +: DW];
            win_wr    = req_wr[i];
            win_rd    = req_rd[i] & ~req_wr[i];
         end
      end
      if (!any || !rst_n) begin
         sel_addr  = '0;
         sel_wdata = '0;
         win_rd    = 1'b0;
         win_wr    = 1'b0;
      end
   end

   assign mem_rd_req = win_rd;
   assign mem_wr_req = win_wr;
   assign mem_addr   = sel_addr;
   assign mem_wdata  = sel_wdata;
   assign rd_fire    = win_rd & mem_rd_gnt;
   assign wr_fire    = win_wr & mem_wr_gnt;

   always_comb begin
      req_rd_gnt = '0;
      req_wr_gnt = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (win == 2'(i)) begin
            req_rd_gnt[i] = rd_fire;
            req_wr_gnt[i] = wr_fire;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rr_ptr <= '0;
      end else if (rd_fire || wr_fire) begin
         rr_ptr <= (int'(win) == NREQ - 1) ? '0 : PW'(win + 2'd1);
      end
   end

   // Tag pipe tracks which requester owns each read still inside the slave.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int s = 0; s < RD_LAT; s++) tag_q[s] <= '0;
      end else begin
         tag_q[0] <= '{vld: rd_fire, owner: win};
         for (int s = 1; s < RD_LAT; s++) tag_q[s] <= tag_q[s-1];
      end
   end

   always_comb begin
      req_rvalid = '0;
      req_rdata  = '0;
      if (tag_q[RD_LAT-1].vld) begin
         req_rdata = mem_rd_data;
         for (int i = 0; i < NREQ; i++) begin
            if (tag_q[RD_LAT-1].owner == 2'(i)) req_rvalid[i] = 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed plus random stimulus against a queue-based reference of the shared memory port.
module tb_mem_port_arbiter;

   localparam int NREQ   = 2;
   localparam int AW     = 32;
   localparam int DW     = 32;
   localparam int RD_LAT = 2;

   logic              clk = 1'b0;
   logic              rst_n;
   logic [NREQ-1:0]   req_rd, req_wr;
   logic [NREQ*AW-1:0] req_addr;
   logic [NREQ*DW-1:0] req_wdata;
   logic [NREQ-1:0]   req_rd_gnt, req_wr_gnt, req_rvalid;
   logic [DW-1:0]     req_rdata;
   logic              mem_rd_req, mem_wr_req, mem_rd_gnt, mem_wr_gnt;
   logic [AW-1:0]     mem_addr;
   logic [DW-1:0]     mem_wdata, mem_rd_data;

   mem_port_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW), .RD_LAT(RD_LAT)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_rd(req_rd), .req_wr(req_wr), .req_addr(req_addr), .req_wdata(req_wdata),
      .req_rd_gnt(req_rd_gnt), .req_wr_gnt(req_wr_gnt),
      .req_rdata(req_rdata), .req_rvalid(req_rvalid),
      .mem_rd_req(mem_rd_req), .mem_wr_req(mem_wr_req),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rd_gnt(mem_rd_gnt), .mem_wr_gnt(mem_wr_gnt), .mem_rd_data(mem_rd_data)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] pat(input int i);
      return 32'hC0DE_0000 ^ (32'(i) * 32'h0001_0203);
   endfunction

   // Slave: registered read of RD_LAT cycles, write on accept.
   logic [31:0] slv_mem [64];
   logic [31:0] slv_pipe [RD_LAT];
   bit          slv_init = 1'b0;

   always @(posedge clk) begin
      if (!slv_init) begin
         for (int i = 0; i < 64; i++) slv_mem[i] <= pat(i);
         for (int s = 0; s < RD_LAT; s++) slv_pipe[s] <= 32'h0;
         slv_init <= 1'b1;
      end else begin
         for (int s = RD_LAT - 1; s > 0; s--) slv_pipe[s] <= slv_pipe[s-1];
         slv_pipe[0] <= (mem_rd_req && mem_rd_gnt) ? slv_mem[mem_addr[7:2]] : 32'h0;
         if (mem_wr_req && mem_wr_gnt) slv_mem[mem_addr[7:2]] <= mem_wdata;
      end
   end
   assign mem_rd_data = slv_pipe[RD_LAT-1];

   // Reference model state
   typedef struct {
      int          due;
      int          owner;
      logic [31:0] data;
   } ret_t;

   bit          p_rd [NREQ];
   bit          p_wr [NREQ];
   logic [31:0] p_addr [NREQ];
   logic [31:0] p_wd [NREQ];
   logic [31:0] ref_mem [64];
   ret_t        rq [$];
   int          mptr, cyc;
   int          wait_cnt [NREQ];
   int          errors = 0, checks = 0;

   logic [1:0]  obs_rgnt, obs_wgnt, obs_rvalid;
   logic [31:0] obs_rdata, obs_addr;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic drive();
      for (int k = 0; k < NREQ; k++) begin
         req_rd[k]             = p_rd[k];
         req_wr[k]             = p_wr[k];
         req_addr[k*AW +: AW]  = p_addr[k];
         req_wdata[k*DW +: DW] = p_wd[k];
      end
   endtask

   task automatic check_zero(input string tag);
      chk({tag, "_rd_gnt"}, 64'(req_rd_gnt), 0);
      chk({tag, "_wr_gnt"}, 64'(req_wr_gnt), 0);
      chk({tag, "_rvalid"}, 64'(req_rvalid), 0);
      chk({tag, "_rdata"},  64'(req_rdata), 0);
      chk({tag, "_mem_rd"}, 64'(mem_rd_req), 0);
      chk({tag, "_mem_wr"}, 64'(mem_wr_req), 0);
      chk({tag, "_mem_addr"}, 64'(mem_addr), 0);
      chk({tag, "_mem_wdata"}, 64'(mem_wdata), 0);
   endtask

   // Called at a negedge; asserts reset with requests active, then releases.
   task automatic do_reset(input string tag);
      rst_n      = 1'b0;
      req_rd     = 2'b11;
      req_wr     = 2'b00;
      req_addr   = {32'h44, 32'h40};
      req_wdata  = {32'h1111, 32'h2222};
      mem_rd_gnt = 1'b1;
      mem_wr_gnt = 1'b1;
      #1;
      check_zero(tag);
      rq.delete();
      mptr = 0;
      for (int k = 0; k < NREQ; k++) begin
         p_rd[k] = 0; p_wr[k] = 0; wait_cnt[k] = 0;
      end
      @(negedge clk);
      check_zero(tag);
      rst_n = 1'b1;
      drive();
   endtask

   // One clock: drive pending ops, compare outputs with the model, advance the model.
   task automatic step();
      bit          any, e_rd, e_wr;
      int          w, j;
      logic [1:0]  erv;
      logic [31:0] erd;
      ret_t        r;
      drive();
      #1;
      any = 0; w = 0;
      for (int k = NREQ - 1; k >= 0; k--) begin
         j = (mptr + k) % NREQ;
         if (p_rd[j] || p_wr[j]) begin any = 1; w = j; end
      end
      e_wr = any && p_wr[w];
      e_rd = any && p_rd[w] && !p_wr[w];
      chk("mem_rd_req", 64'(mem_rd_req), 64'(e_rd));
      chk("mem_wr_req", 64'(mem_wr_req), 64'(e_wr));
      chk("mem_addr",  64'(mem_addr),  any ? 64'(p_addr[w]) : 64'h0);
      chk("mem_wdata", 64'(mem_wdata), any ? 64'(p_wd[w]) : 64'h0);
      chk("rd_gnt", 64'(req_rd_gnt), (e_rd && mem_rd_gnt) ? 64'(1 << w) : 64'h0);
      chk("wr_gnt", 64'(req_wr_gnt), (e_wr && mem_wr_gnt) ? 64'(1 << w) : 64'h0);
      erv = '0; erd = '0;
      if (rq.size() > 0 && rq[0].due == cyc) begin
         erv = 2'(1 << rq[0].owner);
         erd = rq[0].data;
         void'(rq.pop_front());
      end
      chk("rvalid", 64'(req_rvalid), 64'(erv));
      chk("rdata",  64'(req_rdata),  64'(erd));
      obs_rgnt = req_rd_gnt; obs_wgnt = req_wr_gnt;
      obs_rvalid = req_rvalid; obs_rdata = req_rdata; obs_addr = mem_addr;
      // Fairness, judged from the grants the DUT actually issued
      if ((obs_rgnt | obs_wgnt) != 0) begin
         for (int k = 0; k < NREQ; k++) begin
            if (obs_rgnt[k] || obs_wgnt[k]) begin
               chk("starve_bound", 64'(wait_cnt[k] <= NREQ - 1), 64'd1);
               wait_cnt[k] = 0;
            end else if (p_rd[k] || p_wr[k]) begin
               wait_cnt[k]++;
            end
         end
      end
      if (e_rd && mem_rd_gnt) begin
         r.due = cyc + RD_LAT; r.owner = w; r.data = ref_mem[p_addr[w][7:2]];
         rq.push_back(r);
         p_rd[w] = 0;
      end
      if (e_wr && mem_wr_gnt) begin
         ref_mem[p_addr[w][7:2]] = p_wd[w];
         p_wr[w] = 0;
      end
      if ((e_rd && mem_rd_gnt) || (e_wr && mem_wr_gnt)) mptr = (w + 1) % NREQ;
      @(posedge clk);
      cyc++;
      @(negedge clk);
   endtask

   initial begin
      int unsigned rv;
      rst_n = 1'b0;
      req_rd = '0; req_wr = '0; req_addr = '0; req_wdata = '0;
      mem_rd_gnt = 1'b0; mem_wr_gnt = 1'b0;
      cyc = 0; mptr = 0;
      for (int i = 0; i < 64; i++) ref_mem[i] = pat(i);
      for (int k = 0; k < NREQ; k++) begin
         p_rd[k] = 0; p_wr[k] = 0; p_addr[k] = 0; p_wd[k] = 0; wait_cnt[k] = 0;
      end
      @(negedge clk);
      @(negedge clk);

      // Reset with both requesters reading
      do_reset("reset");

      // Contention straight after reset: pointer starts at requester 0
      mem_rd_gnt = 1'b1; mem_wr_gnt = 1'b1;
      p_addr[0] = 32'h0; p_addr[1] = 32'h4;
      for (int i = 0; i < 4 + RD_LAT; i++) begin
         if (i < 4) begin p_rd[0] = 1; p_rd[1] = 1; end
         else begin p_rd[0] = 0; p_rd[1] = 0; end
         step();
         if (i < 4) chk("cont_gnt", 64'(obs_rgnt), (i % 2 == 0) ? 64'h1 : 64'h2);
         if (i >= RD_LAT) chk("cont_rvalid", 64'(obs_rvalid), ((i - RD_LAT) % 2 == 0) ? 64'h1 : 64'h2);
      end

      // Single read of word 2
      p_rd[0] = 1; p_addr[0] = 32'h8;
      step();
      chk("single_gnt", 64'(obs_rgnt), 64'h1);
      for (int i = 1; i < RD_LAT; i++) begin
         step();
         chk("single_early", 64'(obs_rvalid), 64'h0);
      end
      step();
      chk("single_rvalid", 64'(obs_rvalid), 64'h1);
      chk("single_rdata", 64'(obs_rdata), 64'(pat(2)));

      // Slave stall: requester 1 holds the slot until accepted
      p_rd[0] = 1; p_rd[1] = 1; p_addr[0] = 32'h10; p_addr[1] = 32'h14;
      mem_rd_gnt = 1'b0;
      for (int i = 0; i < 3; i++) begin
         step();
         chk("stall_gnt", 64'(obs_rgnt), 64'h0);
         chk("stall_addr", 64'(obs_addr), 64'h14);
      end
      mem_rd_gnt = 1'b1;
      step();
      chk("stall_first", 64'(obs_rgnt), 64'h2);
      step();
      chk("stall_second", 64'(obs_rgnt), 64'h1);

      // Mixed write (req1) and read of the same word (req0)
      p_wr[1] = 1; p_addr[1] = 32'h40; p_wd[1] = 32'hDEAD;
      p_rd[0] = 1; p_addr[0] = 32'h40;
      step();
      chk("mixed_wgnt", 64'(obs_wgnt), 64'h2);
      step();
      chk("mixed_rgnt", 64'(obs_rgnt), 64'h1);
      step();
      chk("mixed_wr_no_rvalid", 64'(obs_rvalid), 64'h0);
      step();
      chk("mixed_rvalid", 64'(obs_rvalid), 64'h1);
      chk("mixed_rdata", 64'(obs_rdata), 64'hDEAD);

      // Read in flight dropped by a reset pulse
      p_rd[1] = 1; p_addr[1] = 32'h20;
      step();
      chk("mid_gnt", 64'(obs_rgnt | obs_wgnt) != 0 ? 64'd1 : 64'd0, 64'd1);
      do_reset("mid_reset");
      mem_rd_gnt = 1'b1; mem_wr_gnt = 1'b1;
      for (int i = 0; i < RD_LAT + 1; i++) begin
         step();
         chk("mid_no_rvalid", 64'(obs_rvalid), 64'h0);
      end
      p_rd[1] = 1; p_addr[1] = 32'h20;
      step();
      for (int i = 1; i < RD_LAT; i++) step();
      step();
      chk("post_rvalid", 64'(obs_rvalid), 64'h2);
      chk("post_rdata", 64'(obs_rdata), 64'(pat(8)));

      // Random traffic with random slave stalls
      for (int n = 0; n < 400; n++) begin
         for (int k = 0; k < NREQ; k++) begin
            if (!p_rd[k] && !p_wr[k] && $urandom_range(0, 9) < 6) begin
               rv = $urandom_range(0, 9);
               p_addr[k] = {24'h0, 6'($urandom_range(0, 63)), 2'b00};
               p_wd[k]   = $urandom;
               p_rd[k]   = (rv < 6) || (rv == 9);
               p_wr[k]   = (rv >= 6);
            end
         end
         mem_rd_gnt = ($urandom_range(0, 3) != 0);
         mem_wr_gnt = ($urandom_range(0, 3) != 0);
         step();
      end
      for (int k = 0; k < NREQ; k++) begin p_rd[k] = 0; p_wr[k] = 0; end
      for (int i = 0; i < RD_LAT + 1; i++) step();
      chk("drained", 64'(rq.size()), 64'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
